up_down_counter: RTL and testbench

UP_DOWN_COUNTER -- requirements
Module: up_down_counter

---
 rtl/up_down_counter.sv | 84 ++++++++
 tb/tb_up_down_counter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/up_down_counter.sv
// Modulo-MODULUS up/down counter with clamped parallel load, terminal-count flag and wrap pulse.
// Define UP_DOWN_COUNTER_SAT_EN to add the sat_mode port (saturate instead of wrap).
module up_down_counter #(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
`ifdef UP_DOWN_COUNTER_SAT_EN
  input  logic             sat_mode,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL    = WIDTH'(MODULUS - 64'd1);
  localparam bit               FULL_RANGE = (MODULUS == (64'd1 << WIDTH));

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;

  logic             w_at_max;
  logic             w_at_zero;
  logic             w_sat;
  logic             w_carry;
  logic             w_borrow;
  logic             w_wrap_up;
  logic             w_wrap_dn;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_dec;
  logic [WIDTH-1:0] w_next_up;
  logic [WIDTH-1:0] w_next_dn;
  logic [WIDTH-1:0] w_load_val;

`ifdef UP_DOWN_COUNTER_SAT_EN
  assign w_sat = sat_mode;
`else
  assign w_sat = 1'b0;
`endif

  assign w_at_max  = (r_count == MAX_VAL);
  assign w_at_zero = (r_count == '0);

  // With a power-of-two modulus the adder carry/borrow is the wrap indication.
  assign {w_carry,  w_inc} = {1'b0, r_count} + (WIDTH+1)'(1);
  assign {w_borrow, w_dec} = {1'b0, r_count} - (WIDTH+1)'(1);

  assign w_wrap_up = FULL_RANGE ? w_carry  : w_at_max;
  assign w_wrap_dn = FULL_RANGE ? w_borrow : w_at_zero;
  assign w_next_up = w_wrap_up ? '0      : w_inc;
  assign w_next_dn = w_wrap_dn ? MAX_VAL : w_dec;

  assign w_load_val = (64'(load_data) < MODULUS) ? load_data : MAX_VAL;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (load) begin
      r_count <= w_load_val;
      r_wrap  <= 1'b0;
    end else if (en) begin
      if (up) begin
        if (!(w_wrap_up && w_sat)) r_count <= w_next_up;
        r_wrap <= w_wrap_up && !w_sat;
      end else begin
        if (!(w_wrap_dn && w_sat)) r_count <= w_next_dn;
        r_wrap <= w_wrap_dn && !w_sat;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;
  assign tc    = en && ((up && w_at_max) || (!up && w_at_zero));

endmodule

// File: tb/tb_up_down_counter.sv
// Directed bench for up_down_counter: MODULUS=10 instance plus a full-range MODULUS=16 instance.
module tb_up_down_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_data;
`ifdef UP_DOWN_COUNTER_SAT_EN
  logic       sat_mode;
`endif

  logic [3:0] count;
  logic       tc;
  logic       wrap;
  logic [3:0] f_count;
  logic       f_tc;
  logic       f_wrap;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  up_down_counter #(.WIDTH(4), .MODULUS(10)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .up        (up),
    .load      (load),
    .load_data (load_data),
`ifdef UP_DOWN_COUNTER_SAT_EN
    .sat_mode  (sat_mode),
`endif
    .count     (count),
    .tc        (tc),
    .wrap      (wrap)
  );

  up_down_counter #(.WIDTH(4), .MODULUS(16)) u_full (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .up        (up),
    .load      (load),
    .load_data (load_data),
`ifdef UP_DOWN_COUNTER_SAT_EN
    .sat_mode  (sat_mode),
`endif
    .count     (f_count),
    .tc        (f_tc),
    .wrap      (f_wrap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string tag, input logic [3:0] c, input logic w, input logic t);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".wrap"},  32'(wrap),  32'(w));
    chk({tag, ".tc"},    32'(tc),    32'(t));
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_data = 4'd0;
`ifdef UP_DOWN_COUNTER_SAT_EN
    sat_mode = 1'b0;
`endif
    #2;

    // reset state; tc during reset with en=1, up=0
    step();
    chk3("reset", 4'd0, 1'b0, 1'b0);
    en = 1'b1; up = 1'b0; #1;
    chk("reset_tc_down", 32'(tc), 32'd1);
    step();
    chk3("reset_en_down", 4'd0, 1'b0, 1'b1);

    // up-wrap through 0..9..0
    reset = 1'b0; up = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk3($sformatf("upwrap%0d", k), 4'(k % 10), (k == 10), ((k % 10) == 9));
    end
    en = 1'b0;
    step();
    chk3("hold_after_wrap", 4'd0, 1'b0, 1'b0);

    // down-wrap from loaded 2
    load = 1'b1; load_data = 4'd2;
    step();
    chk3("load2", 4'd2, 1'b0, 1'b0);
    load = 1'b0; en = 1'b1; up = 1'b0;
    step(); chk3("down1", 4'd1, 1'b0, 1'b0);
    step(); chk3("down0", 4'd0, 1'b0, 1'b1);
    step(); chk3("down9", 4'd9, 1'b1, 1'b0);
    en = 1'b0;
    step(); chk3("down_hold", 4'd9, 1'b0, 1'b0);

    // load clamping, boundary and priority over en / under reset
    load = 1'b1; load_data = 4'd13; en = 1'b1; up = 1'b1;
    step(); chk3("load13_clamp", 4'd9, 1'b0, 1'b1);
    load_data = 4'd10;
    step(); chk3("load10_clamp", 4'd9, 1'b0, 1'b1);
    load_data = 4'd8;
    step(); chk3("load8", 4'd8, 1'b0, 1'b0);
    reset = 1'b1;
    step(); chk3("reset_over_load", 4'd0, 1'b0, 1'b0);
    reset = 1'b0; load = 1'b0;

    // direction change applies on the same edge
    step(); chk3("dir_up1", 4'd1, 1'b0, 1'b0);
    step(); chk3("dir_up2", 4'd2, 1'b0, 1'b0);
    up = 1'b0;
    step(); chk3("dir_down1", 4'd1, 1'b0, 1'b0);

    // reset right before an up-wrap
    load = 1'b1; load_data = 4'd9;
    step(); load = 1'b0; up = 1'b1; #1;
    chk3("pre_wrap", 4'd9, 1'b0, 1'b1);
    reset = 1'b1;
    step(); chk3("reset_mid_wrap", 4'd0, 1'b0, 1'b0);
    reset = 1'b0; en = 1'b0;
    step(); chk3("after_reset", 4'd0, 1'b0, 1'b0);

    // full-range instance: binary overflow/underflow
    reset = 1'b1; step(); reset = 1'b0;
    chk("full_reset", 32'(f_count), 32'd0);
    load = 1'b1; load_data = 4'd15;
    step(); load = 1'b0; en = 1'b1; up = 1'b1; #1;
    chk("full_load15", 32'(f_count), 32'd15);
    chk("full_tc15", 32'(f_tc), 32'd1);
    chk("clamp15", 32'(count), 32'd9);
    step();
    chk("full_wrap_count", 32'(f_count), 32'd0);
    chk("full_wrap_pulse", 32'(f_wrap), 32'd1);
    en = 1'b0;
    step();
    chk("full_hold", 32'(f_count), 32'd0);
    chk("full_wrap_end", 32'(f_wrap), 32'd0);
    en = 1'b1; up = 1'b0;
    step();
    chk("full_under_count", 32'(f_count), 32'd15);
    chk("full_under_pulse", 32'(f_wrap), 32'd1);
    en = 1'b0;

`ifdef UP_DOWN_COUNTER_SAT_EN
    // saturation at both ends, then back to wrap mode
    sat_mode = 1'b1; load = 1'b1; load_data = 4'd9;
    step(); load = 1'b0; en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk3($sformatf("sat_up%0d", k), 4'd9, 1'b0, 1'b1);
    end
    load = 1'b1; load_data = 4'd0;
    step(); load = 1'b0; up = 1'b0;
    step(); chk3("sat_down", 4'd0, 1'b0, 1'b1);
    sat_mode = 1'b0;
    step(); chk3("nosat_down", 4'd9, 1'b1, 1'b0);
    en = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
